// File: rtl/uart_rx_deserializer_if.sv
// Byte-stream output bundle of the UART receive front end.
// The deserializer drives it (master); the packing stage consumes it (slave).
`default_nettype none

interface uart_rx_deserializer_if;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_endofpacket;
  logic       rx_idle;
  logic       frame_error;

  modport master (
    output rx_data,
    output rx_data_ready,
    output rx_endofpacket,
    output rx_idle,
    output frame_error
  );

  modport slave (
    input rx_data,
    input rx_data_ready,
    input rx_endofpacket,
    input rx_idle,
    input frame_error
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling 8N1 receiver with idle-gap packet delimiting.
// Rev 1.0 - initial release.
`default_nettype none

module uart_rx_deserializer #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115_200,
  parameter int OVERSAMPLE    = 8,
  parameter int IDLE_GAP_BITS = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              rx,
  uart_rx_deserializer_if.master bus
);

  localparam int DIV     = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W   = $clog2(DIV);
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int GAP_MAX = IDLE_GAP_BITS * OVERSAMPLE;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic r_rx_meta, r_rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_div_cnt <= '0;
    else        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
  end

  logic [2:0]      r_state, w_next_state;
  logic [OS_W-1:0] r_os_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            w_os_mid, w_os_last;

  assign w_os_mid  = (r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign w_os_last = (r_os_cnt == OS_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_tick) begin
      case (r_state)
        S_IDLE:  if (!r_rxs) w_next_state = S_START;
        S_START: if (w_os_mid) w_next_state = r_rxs ? S_IDLE : S_DATA;
        S_DATA:  if (w_os_last && (r_bit_cnt == 3'd7)) w_next_state = S_STOP;
        S_STOP:  if (w_os_last) w_next_state = r_rxs ? S_IDLE : S_BREAK;
        S_BREAK: if (r_rxs) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Bit-timing datapath; it only moves on baud ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_tick) begin
      case (r_state)
        S_START: begin
          r_os_cnt  <= w_os_mid ? '0 : r_os_cnt + 1'b1;
          r_bit_cnt <= '0;
        end
        S_DATA: begin
          if (w_os_last) begin
            r_shift[r_bit_cnt] <= r_rxs;
            r_os_cnt           <= '0;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
          end else begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        S_STOP:  r_os_cnt <= w_os_last ? '0 : r_os_cnt + 1'b1;
        default: r_os_cnt <= '0;
      endcase
    end
  end

  logic [7:0]       r_rx_data, w_rx_data_next;
  logic             r_data_ready, r_frame_error, r_eop, r_idle, r_pending;
  logic             w_data_ready, w_frame_error, w_eop, w_pending_next;
  logic [GAP_W-1:0] r_gap, w_gap_next;

  always_comb begin
    w_data_ready   = 1'b0;
    w_frame_error  = 1'b0;
    w_eop          = 1'b0;
    w_rx_data_next = r_rx_data;
    w_pending_next = r_pending;
    w_gap_next     = r_gap;

    if (w_tick && (r_state == S_STOP) && w_os_last) begin
      if (r_rxs) begin
        w_data_ready   = 1'b1;
        w_rx_data_next = r_shift;
        w_pending_next = 1'b1;
      end else begin
        w_frame_error = 1'b1;
      end
    end

    // Gap only accumulates on a quiet high line in IDLE; a low sample restarts it.
    if (r_state != S_IDLE) begin
      w_gap_next = '0;
    end else if (w_tick) begin
      if (!r_rxs) begin
        w_gap_next = '0;
      end else if (r_gap != GAP_W'(GAP_MAX)) begin
        w_gap_next = r_gap + 1'b1;
        if ((r_gap == GAP_W'(GAP_MAX - 1)) && r_pending) begin
          w_eop          = 1'b1;
          w_pending_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data     <= 8'h00;
      r_data_ready  <= 1'b0;
      r_frame_error <= 1'b0;
      r_eop         <= 1'b0;
      r_idle        <= 1'b0;
      r_pending     <= 1'b0;
      r_gap         <= '0;
    end else begin
      r_rx_data     <= w_rx_data_next;
      r_data_ready  <= w_data_ready;
      r_frame_error <= w_frame_error;
      r_eop         <= w_eop;
      r_idle        <= (w_gap_next == GAP_W'(GAP_MAX));
      r_pending     <= w_pending_next;
      r_gap         <= w_gap_next;
    end
  end

  assign bus.rx_data        = r_rx_data;
  assign bus.rx_data_ready  = r_data_ready;
  assign bus.rx_endofpacket = r_eop;
  assign bus.rx_idle        = r_idle;
  assign bus.frame_error    = r_frame_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: a frame-level scoreboard checks outputs every cycle.
`default_nettype none

module tb_uart_rx_deserializer;

  localparam int CLK_FREQ      = 8_000_000;
  localparam int BAUD          = 125_000;
  localparam int OVERSAMPLE    = 8;
  localparam int IDLE_GAP_BITS = 16;
  localparam int BITCLK        = CLK_FREQ / BAUD;                // 64 clocks per bit
  localparam int GAP_CLK       = IDLE_GAP_BITS * OVERSAMPLE * 8; // 1024 clocks

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  uart_rx_deserializer_if u_if ();

  uart_rx_deserializer #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .OVERSAMPLE    (OVERSAMPLE),
    .IDLE_GAP_BITS (IDLE_GAP_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected frame outcomes: bit 8 set = frame error, else a good byte in [7:0].
  logic [8:0] exp_q[$];
  logic [7:0] m_data    = 8'h00;
  logic       m_pending = 1'b0;
  int n_ready = 0, n_ferr = 0, n_eop = 0;
  int last_ready_cyc = 0, last_eop_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (reset) begin
      check("pulses_exclusive",
            32'((int'(u_if.rx_data_ready) + int'(u_if.frame_error) + int'(u_if.rx_endofpacket)) <= 1), 1);
      if (u_if.rx_data_ready) begin
        check("ready_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ready_kind", 32'(e[8]), 0);
          check("ready_byte", 32'(u_if.rx_data), 32'(e[7:0]));
          m_data = e[7:0];
        end
        m_pending = 1'b1;
        n_ready++;
        last_ready_cyc = cyc;
      end else begin
        check("rx_data_hold", 32'(u_if.rx_data), 32'(m_data));
      end
      if (u_if.frame_error) begin
        check("ferr_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ferr_kind", 32'(e[8]), 1);
        end
        n_ferr++;
      end
      if (u_if.rx_endofpacket) begin
        check("eop_needs_pending", 32'(m_pending), 1);
        check("eop_with_idle", 32'(u_if.rx_idle), 1);
        m_pending = 1'b0;
        n_eop++;
        last_eop_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 = no outcome expected, 1 = good byte, 2 = frame error
  task automatic send(input logic [7:0] b, input logic stopb, input int kind);
    if (kind == 1) exp_q.push_back({1'b0, b});
    else if (kind == 2) exp_q.push_back({1'b1, b});
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    rx = stopb;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(u_if.rx_data), 32'h00);
    check({tag, "_ready"},   32'(u_if.rx_data_ready), 0);
    check({tag, "_eop"},     32'(u_if.rx_endofpacket), 0);
    check({tag, "_idle"},    32'(u_if.rx_idle), 0);
    check({tag, "_ferr"},    32'(u_if.frame_error), 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r0, f0, e0;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Idle from reset: rx_idle rises, no packet end without a byte.
    repeat (100) @(negedge clk);
    check("idle_not_yet", 32'(u_if.rx_idle), 0);
    idle(1900);
    check("idle_after_gap", 32'(u_if.rx_idle), 1);
    check("no_eop_from_reset", 32'(n_eop), 0);

    // Single byte
    r0 = n_ready; f0 = n_ferr;
    send(8'hA5, 1'b1, 1);
    idle(1200);
    check("single_ready_count", 32'(n_ready - r0), 1);
    check("single_data", 32'(u_if.rx_data), 32'hA5);
    check("single_no_ferr", 32'(n_ferr - f0), 0);
    check("single_eop_count", 32'(n_eop), 1);

    // Glitch rejection
    r0 = n_ready; f0 = n_ferr;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    idle(300);
    check("glitch_no_ready", 32'(n_ready - r0), 0);
    check("glitch_no_ferr", 32'(n_ferr - f0), 0);
    send(8'h3C, 1'b1, 1);
    idle(200);
    check("after_glitch_data", 32'(u_if.rx_data), 32'h3C);

    // Frame error: prior byte 0x81 must survive
    send(8'h81, 1'b1, 1);
    idle(200);
    r0 = n_ready; f0 = n_ferr;
    send(8'h3C, 1'b0, 2);
    rx = 1'b0;
    repeat (3 * BITCLK) @(negedge clk);
    check("ferr_count", 32'(n_ferr - f0), 1);
    check("ferr_no_ready", 32'(n_ready - r0), 0);
    check("ferr_data_kept", 32'(u_if.rx_data), 32'h81);
    idle(1200);
    check("ferr_break_no_ready", 32'(n_ready - r0), 0);

    // Packet end after three back-to-back bytes
    r0 = n_ready; e0 = n_eop;
    send(8'h01, 1'b1, 1);
    send(8'h02, 1'b1, 1);
    send(8'h03, 1'b1, 1);
    idle(3000);
    check("pkt_ready_count", 32'(n_ready - r0), 3);
    check("pkt_eop_count", 32'(n_eop - e0), 1);
    check("pkt_eop_delay_lo", 32'((last_eop_cyc - last_ready_cyc) >= GAP_CLK - 8), 1);
    check("pkt_eop_delay_hi", 32'((last_eop_cyc - last_ready_cyc) <= GAP_CLK + 8), 1);
    check("pkt_last_data", 32'(u_if.rx_data), 32'h03);
    check("pkt_idle", 32'(u_if.rx_idle), 1);

    // Reset in the middle of data bit 4 of 0xFF
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (BITCLK) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BITCLK / 2) @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    m_data    = 8'h00;
    m_pending = 1'b0;
    #1;
    check_reset_outputs("midbyte_reset");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    r0 = n_ready;
    idle(100);
    check("post_reset_no_ready", 32'(n_ready - r0), 0);
    send(8'h5A, 1'b1, 1);
    idle(100);
    check("post_reset_ready", 32'(n_ready - r0), 1);
    check("post_reset_data", 32'(u_if.rx_data), 32'h5A);
    check("all_frames_seen", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side serial front end: oversamples the asynchronous `rx` line, recovers 8N1 bytes (LSB first), and flags the end of a packet after a configurable idle gap. It sits directly upstream of the UART packing stage. That stage consumes `rx_data` and `rx_data_ready` as a byte stream and uses `rx_endofpacket` to mark a complete numeric packet.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency, Hz.
- `BAUD`, 115_200: line rate, bits/s.
- `OVERSAMPLE`, 8: baud ticks per bit period. Must be even and ≥4.
- `IDLE_GAP_BITS`, 16: idle bit periods that end a packet.
- `clk`, in, 1: system clock. All logic runs on the rising edge.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `rx`, in, 1: serial line. Asynchronous to `clk`; idles high.
- `rx_data`, out, 8: last good byte. Holds until the next good byte.
- `rx_data_ready`, out, 1: one-cycle pulse when `rx_data` is updated.
- `rx_endofpacket`, out, 1: one-cycle pulse when an idle gap follows at least one received byte.
- `rx_idle`, out, 1: high while the idle-gap counter is saturated.
- `frame_error`, out, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Input synchroniser:** 2-flop on `rx`, both flops reset to 1. All decisions use the synchronised value `rxs`.
- **Tick generator:**
  - `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, truncating integer division; `DIV` must be ≥2.
  - A counter runs 0..DIV-1 continuously. `tick` is high for one clock when the counter is at DIV-1.
- **State machine:** states IDLE, START, DATA, STOP, BREAK. `os_cnt` and `bit_cnt` advance only on `tick`.
  - **IDLE:** on `tick` with `rxs=0`, go to START with `os_cnt=0`.
  - **START:** increment `os_cnt` on each tick. At `os_cnt=OVERSAMPLE/2-1` (mid start bit), sample `rxs`.
    - If `rxs=0`: go to DATA with `os_cnt=0`, `bit_cnt=0`.
    - If `rxs=1`: false start, return to IDLE with no output.
  - **DATA:** at each `os_cnt=OVERSAMPLE-1`, shift `rxs` into bit[`bit_cnt`] (LSB first), clear `os_cnt`, and increment `bit_cnt`. After bit 7, go to STOP.
  - **STOP:** at `os_cnt=OVERSAMPLE-1`, sample `rxs`.
    - If `rxs=1`: load the shift register into `rx_data`, pulse `rx_data_ready`, set the pending-packet flag, go to IDLE.
    - If `rxs=0`: pulse `frame_error`, discard the byte, go to BREAK.
  - **BREAK:** stay until a tick with `rxs=1`, then go to IDLE. No start bit is accepted in BREAK.
- **Idle-gap counter:**
  - Counts ticks while in IDLE with `rxs=1`, saturating at `IDLE_GAP_BITS*OVERSAMPLE`.
  - Clears on entry to START, and in any non-IDLE state.
  - On the tick where it reaches saturation with the pending flag set: pulse `rx_endofpacket` and clear the pending flag.
  - `rx_idle` = counter saturated.
- **Width rules:**
  - `os_cnt` is `$clog2(OVERSAMPLE)` bits and `bit_cnt` is 3 bits.
  - The gap counter is `$clog2(IDLE_GAP_BITS*OVERSAMPLE+1)` bits and never wraps.
- **Reset values:**
  - `rx_data=8'h00`; `rx_data_ready`, `rx_endofpacket`, `frame_error` = 0.
  - `rx_idle=0`, state=IDLE, gap counter=0, pending=0.
  - An asserted reset aborts any byte in flight with no partial output.

## Timing
- All outputs are registered.
- `rx_data_ready` and `frame_error` assert in the clock after the stop-bit sample tick. `rx_data` is valid in that same cycle.
- Line-to-output latency is 2 clocks (synchroniser) plus tick quantisation (≤DIV clocks) plus 9.5 bit periods.
- `rx_data_ready`, `frame_error` and `rx_endofpacket` are mutually exclusive in any cycle.
- A start bit may begin on the tick immediately after the STOP→IDLE transition, so back-to-back bytes are supported.
- A line that goes low during the gap count clears the count. The pending flag survives, so the packet continues.
- After reset release, `rx_idle` rises after `IDLE_GAP_BITS*OVERSAMPLE` ticks of high line. No `rx_endofpacket` fires, because pending=0.

## Test plan
Bench parameters: `CLK_FREQ=8_000_000`, `BAUD=125_000`, `OVERSAMPLE=8`, `IDLE_GAP_BITS=16`. This gives `DIV=8`, 64 clocks per bit.

- **Single byte:** drive 8'hA5 as 8N1 → exactly one `rx_data_ready` pulse with `rx_data=8'hA5`; `frame_error` stays 0.
- **Glitch rejection:** pull `rx` low for 16 clocks, then high → no outputs; state returns to IDLE; a following 8'h3C is received correctly.
- **Frame error:** drive 8'h3C with the stop bit low, and hold low 3 more bit periods → one `frame_error` pulse and no `rx_data_ready`. `rx_data` keeps its prior value. Bytes are accepted again only after the line returns high.
- **Packet end:** send 8'h01, 8'h02, 8'h03 back-to-back, then idle high → three ready pulses, then one `rx_endofpacket` pulse 1024 clocks (±8) after the third byte's stop-sample tick. `rx_idle` rises in the same cycle. Further idle produces no second pulse.
- **Reset mid-byte:** assert `reset` low during data bit 4 of 8'hFF → all outputs go to reset values immediately; no ready pulse. After release with the line high, 8'h5A is received correctly.
- **Idle from reset:** hold `rx` high for 2000 clocks after reset → `rx_idle` rises and `rx_endofpacket` never pulses.
